hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It consumes the ID/EX pipeline register outputs (MemRead, rt) and the IF/ID source fields. It drives the control inputs of the pipeline registers: PC write-enable, IF/ID write-enable and flush, the ID/EX flush (bubble insert), and a global hold for data-memory wait states. It sits in the ID stage, beside the forwarding unit.

## Interface
- COUNT_W, 32, width of each performance counter
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_ex_MemRead  in  1  instruction in EX is a load
- id_ex_rt  in  5  load destination register in EX
- if_id_rs  in  5  rs field of the instruction in ID
- if_id_rt  in  5  rt field of the instruction in ID
- if_id_use_rt  in  1  instruction in ID reads rt (R-type, store, beq)
- branch_taken  in  1  branch resolved taken in EX
- dmem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  drives ID_EX register flush (bubble)
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- state  out  2  FSM state (debug)
- stall_cnt, flush_cnt, wait_cnt  out  COUNT_W each  performance counters

## Operation
- FSM states: RUN=0, BUBBLE=1, WAIT=2. Encoding 3 is illegal and returns to RUN.
- load_use = id_ex_MemRead & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_use_rt & (id_ex_rt == if_id_rt))).
- br = branch_taken | branch_pend.
- Default outputs: pc_write=1, if_id_write=1, all flushes 0, pipe_hold=0.
- Priority in RUN and BUBBLE, highest first:
  - dmem_busy: pc_write=0, if_id_write=0, pipe_hold=1, no flushes. Next state WAIT. branch_pend <= branch_taken.
  - br: if_id_flush=1, id_ex_flush=1, PC loads the branch target. Next state RUN. branch_pend cleared. flush_cnt +1.
  - load_use, in RUN only: pc_write=0, if_id_write=0, id_ex_flush=1. Next state BUBBLE. stall_cnt +1.
  - Otherwise: next state RUN.
- BUBBLE lasts one cycle.
  - A load_use term still true in BUBBLE is ignored: no second stall and no second count.
  - BUBBLE then returns to RUN, or goes to WAIT per the priority above.
- WAIT:
  - While dmem_busy=1: hold outputs as on entry. wait_cnt +1 per cycle. branch_pend |= branch_taken.
  - First cycle with dmem_busy=0: evaluate as RUN, using br for the branch term. Next state follows the RUN rules.
- Counters saturate at all-ones; they do not wrap.

## Timing
- All outputs are combinational from the current inputs, state, and branch_pend. Zero-cycle latency to the pipeline register enables.
- state and branch_pend are registered.
- Load-use costs exactly one bubble cycle. The load is then in MEM, so the forwarding unit supplies the operand.
- A taken branch costs two flushed instructions (IF and ID). Effect is in the same cycle as branch_taken.
- Reset (rst=1 at a clock edge):
  - Next-cycle values: state=RUN, branch_pend=0, all counters=0.
  - While rst is high, outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0.
  - Reset asserted in WAIT or BUBBLE aborts the state. A pending branch is discarded.
- Simultaneous events:
  - dmem_busy together with branch_taken: WAIT is entered and the branch is applied on exit.
  - branch_taken together with load_use: branch only, and stall_cnt is unchanged.

## Configuration
- HAZARD_PERF_CNT_EN defined: the three counters and their saturation logic are built.
- Not defined: stall_cnt, flush_cnt and wait_cnt are constant 0, no counter flops exist, and control behaviour is identical.

## Test plan
- Load-use on rs. RUN, id_ex_MemRead=1, id_ex_rt=5, if_id_rs=5.
  - Same cycle: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next cycle: state=1, outputs return to defaults. stall_cnt=1.
- Load to $0, or rt match with if_id_use_rt=0. id_ex_rt=0 and if_id_rs=0; or rt=7 with if_id_use_rt=0.
  - No stall, state stays 0, stall_cnt=0.
- Branch taken with load_use true in the same cycle.
  - if_id_flush=1, id_ex_flush=1, pc_write=1, state stays 0.
  - flush_cnt=1, stall_cnt=0.
- Memory wait. dmem_busy=1 for 3 cycles, branch_taken pulsed in the 2nd cycle.
  - Busy cycles: pipe_hold=1, pc_write=0, state=2, wait_cnt=3.
  - First cycle with dmem_busy low: both flushes=1. flush_cnt=1.
- Reset mid-WAIT. rst=1 for 1 cycle while state=2 and branch_pend=1.
  - Next cycle: state=0, counters=0, no flush after dmem_busy drops.
- Saturation (HAZARD_PERF_CNT_EN defined, COUNT_W=4). Produce 17 load-use stalls.
  - stall_cnt=15 and holds.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side hazard inputs and pipeline-register controls
interface hazard_ctrl_if;
    logic       id_ex_MemRead;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_use_rt;
    logic       branch_taken;
    logic       dmem_busy;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       pipe_hold;

    modport master (
        output id_ex_MemRead, id_ex_rt, if_id_rs, if_id_rt, if_id_use_rt,
               branch_taken, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold
    );

    modport slave (
        input  id_ex_MemRead, id_ex_rt, if_id_rs, if_id_rt, if_id_use_rt,
               branch_taken, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch / dmem-wait hazard controller for the 5-stage core
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush/wait counters.
module hazard_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_if.slave       hz,
    output logic [1:0]         state,
    output logic [COUNT_W-1:0] stall_cnt,
    output logic [COUNT_W-1:0] flush_cnt,
    output logic [COUNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ILL    = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   branch_pend_q, branch_pend_d;

    logic load_use;
    logic br;
    logic ev_stall, ev_flush, ev_wait;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;

    assign load_use = hz.id_ex_MemRead && (hz.id_ex_rt != 5'd0) &&
                      ((hz.id_ex_rt == hz.if_id_rs) ||
                       (hz.if_id_use_rt && (hz.id_ex_rt == hz.if_id_rt)));

    // A branch resolved while memory was stalled is replayed on WAIT exit.
    assign br = hz.branch_taken || branch_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    always_comb begin
        state_d       = ST_RUN;
        branch_pend_d = 1'b0;
        if (ev_wait) begin
            state_d       = ST_WAIT;
            branch_pend_d = (state_q == ST_WAIT) ? (branch_pend_q || hz.branch_taken)
                                                 : hz.branch_taken;
        end else if (ev_flush) begin
            state_d       = ST_RUN;
            branch_pend_d = 1'b0;
        end else if (ev_stall) begin
            state_d       = ST_BUBBLE;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        ev_stall    = 1'b0;
        ev_flush    = 1'b0;
        ev_wait     = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN, ST_BUBBLE, ST_WAIT: begin
                    if (hz.dmem_busy) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_hold   = 1'b1;
                        ev_wait     = 1'b1;
                    end else if (br) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        ev_flush    = 1'b1;
                    end else if (load_use && (state_q != ST_BUBBLE)) begin
                        // The bubble already separates the load from its user.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        ev_stall    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.if_id_write = if_id_write;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.pipe_hold   = pipe_hold;
    assign state          = state_q;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [COUNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [COUNT_W-1:0] wait_cnt_q,  wait_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (ev_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (ev_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
        if (ev_wait  && (wait_cnt_q  != '1)) wait_cnt_d  = wait_cnt_q  + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed table, corner sequences and random model check of hazard_ctrl
module tb_hazard_ctrl;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    hazard_ctrl_if hz_if ();

    hazard_ctrl #(.COUNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (hz_if.slave),
        .state     (state),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .wait_cnt  (wait_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst, mr;
        logic [4:0] ert, rs, rt;
        logic       ur, br, busy;
        logic [4:0] outs;
        logic [1:0] st;
        int         sc, fc, wc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: mode 0 run, 1 bubble, 2 wait.
    int m_mode, m_stall, m_flush, m_wait;
    bit m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cexp(input int v);
        return PERF ? v : 0;
    endfunction

    function automatic int sat(input int v);
        return (v + 1 > CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [4:0] dut_outs();
        return {hz_if.pc_write, hz_if.if_id_write, hz_if.if_id_flush,
                hz_if.id_ex_flush, hz_if.pipe_hold};
    endfunction

    task automatic drive(input logic r, input logic mr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic br, input logic busy);
        rst                    = r;
        hz_if.id_ex_MemRead    = mr;
        hz_if.id_ex_rt         = ert;
        hz_if.if_id_rs         = rs;
        hz_if.if_id_rt         = rt;
        hz_if.if_id_use_rt     = ur;
        hz_if.branch_taken     = br;
        hz_if.dmem_busy        = busy;
    endtask

    task automatic add(input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic br, input logic busy, input logic [4:0] outs,
                       input logic [1:0] st, input int sc, input int fc, input int wc);
        vec_t v;
        v.rst = r; v.mr = mr; v.ert = ert; v.rs = rs; v.rt = rt;
        v.ur = ur; v.br = br; v.busy = busy; v.outs = outs; v.st = st;
        v.sc = sc; v.fc = fc; v.wc = wc;
        vecs.push_back(v);
    endtask

    // Rule-level model: returns this cycle's controls and advances to the next cycle.
    task automatic model_cycle(input logic r, input logic mr, input logic [4:0] ert,
                               input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                               input logic br_in, input logic busy, output logic [4:0] outs);
        bit lu;
        bit brx;
        lu  = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
        brx = br_in || m_pend;
        if (r) begin
            outs = 5'b00110;
            m_mode = 0; m_pend = 0; m_stall = 0; m_flush = 0; m_wait = 0;
        end else if (busy) begin
            outs   = 5'b00001;
            m_pend = (m_mode == 2) ? (m_pend || br_in) : br_in;
            m_mode = 2;
            m_wait = sat(m_wait);
        end else if (brx) begin
            outs    = 5'b11110;
            m_mode  = 0;
            m_pend  = 0;
            m_flush = sat(m_flush);
        end else if (lu && m_mode != 1) begin
            outs    = 5'b00010;
            m_mode  = 1;
            m_stall = sat(m_stall);
        end else begin
            outs   = 5'b11000;
            m_mode = 0;
        end
    endtask

    initial begin
        logic [4:0] exp_o;
        logic r, mr, ur, br, busy;
        logic [4:0] ert, rs, rt;

        drive(1'b1, 0, 0, 0, 0, 0, 0, 0);

        //  rst mr ert rs rt ur br bz  outs      st sc fc wc
        add(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0, 0, 0);
        add(0, 1, 5, 5, 0, 0, 0, 0, 5'b00010, 1, 1, 0, 0);
        add(0, 1, 5, 5, 0, 0, 0, 0, 5'b11000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 1, 0, 0);
        add(0, 1, 7, 3, 7, 0, 0, 0, 5'b11000, 0, 1, 0, 0);
        add(0, 1, 7, 3, 7, 1, 0, 0, 5'b00010, 1, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 2, 0, 0);
        add(0, 1, 5, 5, 0, 0, 1, 0, 5'b11110, 0, 2, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 5'b00001, 2, 2, 1, 1);
        add(0, 0, 0, 0, 0, 0, 1, 1, 5'b00001, 2, 2, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 1, 5'b00001, 2, 2, 1, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 5'b11110, 0, 2, 2, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 2, 2, 3);
        add(0, 0, 0, 0, 0, 0, 0, 1, 5'b00001, 2, 2, 2, 4);
        add(0, 0, 0, 0, 0, 0, 1, 1, 5'b00001, 2, 2, 2, 5);
        add(1, 0, 0, 0, 0, 0, 0, 1, 5'b00110, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0, 0, 0);
        add(0, 1, 3, 3, 0, 0, 0, 0, 5'b00010, 1, 1, 0, 0);
        add(0, 1, 3, 3, 0, 0, 0, 1, 5'b00001, 2, 1, 0, 1);
        add(0, 1, 3, 3, 0, 0, 0, 0, 5'b00010, 1, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 2, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].mr, vecs[i].ert, vecs[i].rs, vecs[i].rt,
                  vecs[i].ur, vecs[i].br, vecs[i].busy);
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(dut_outs()), 32'(vecs[i].outs));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), cexp(vecs[i].sc));
            chk($sformatf("vec%0d_flush", i), 32'(flush_cnt), cexp(vecs[i].fc));
            chk($sformatf("vec%0d_wait", i),  32'(wait_cnt),  cexp(vecs[i].wc));
        end

        // Saturation: 17 load-use stalls, each followed by its bubble cycle.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            drive(0, 1, 9, 9, 0, 0, 0, 0);
            #1;
            chk("sat_stall_out", 32'(dut_outs()), 32'(5'b00010));
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            if (k == 14) chk("sat_reach", 32'(stall_cnt), cexp(CNT_MAX));
        end
        @(negedge clk);
        chk("sat_hold", 32'(stall_cnt), cexp(CNT_MAX));
        chk("sat_state", 32'(state), 32'd0);

        // Random stimulus against the reference model.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        m_mode = 0; m_pend = 0; m_stall = 0; m_flush = 0; m_wait = 0;
        @(posedge clk);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            r    = ($urandom_range(0, 63) == 0);
            mr   = $urandom_range(0, 1);
            ert  = 5'($urandom_range(0, 3));
            rs   = 5'($urandom_range(0, 3));
            rt   = 5'($urandom_range(0, 3));
            ur   = $urandom_range(0, 1);
            br   = ($urandom_range(0, 7) == 0);
            busy = ($urandom_range(0, 3) == 0);
            drive(r, mr, ert, rs, rt, ur, br, busy);
            model_cycle(r, mr, ert, rs, rt, ur, br, busy, exp_o);
            #1;
            chk("rnd_outs", 32'(dut_outs()), 32'(exp_o));
            @(posedge clk);
            #1;
            chk("rnd_state", 32'(state), m_mode);
            chk("rnd_stall", 32'(stall_cnt), cexp(m_stall));
            chk("rnd_flush", 32'(flush_cnt), cexp(m_flush));
            chk("rnd_wait",  32'(wait_cnt),  cexp(m_wait));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
